rr_encoder_arbiter: RTL
=======================

Name: rr_encoder_arbiter

Overview:
- Four-requester round-robin arbiter that shares one downstream resource among requesters Y0..Y3.
- Registers a one-hot grant and its 2-bit binary encoding, the same 4-to-2 mapping used by the team's encoder datapath.
- Holds a grant while the owner keeps requesting, up to a programmable time-slice, then rotates priority.
- Sits between the request sources and the shared encoder/resource; the encoded index drives the downstream mux select.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant stays asserted; 0 = unlimited (hold until request drops).
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit i = requester Yi
- grant  output  4  registered one-hot grant; all-zero when idle
- grant_idx  output  2  binary index of granted requester (Y0=00, Y1=01, Y2=10, Y3=11); 00 when idle
- grant_valid  output  1  high while any grant is asserted
- timeout  output  1  one-cycle pulse on the edge a grant is revoked by MAX_HOLD expiry

Behaviour:
- Reset (rst_n low, asynchronous; releases on next clk edge after deassert):
  - grant=0000, grant_idx=00, grant_valid=0, timeout=0.
  - Priority pointer ptr=0; hold_cnt=0; state=IDLE.
- All outputs are registered. No combinational path from req to any output.
- Winner selection: the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - req==0000: stay in IDLE.
  - Otherwise, at the next edge: grant the winner, set grant_idx, grant_valid=1, hold_cnt=1, state=GRANT.
  - Latency: request visible at edge k produces a grant at edge k+1.
- GRANT (owner o = grant_idx):
  - Keep: req[o]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD). Grant unchanged; hold_cnt increments, saturating at 2^CNT_W-1.
  - Release: req[o]=0.
    - ptr=o+1 mod 4.
    - Other requests pending: grant the winner from the new ptr at the same edge, back-to-back with no idle cycle; hold_cnt=1.
    - None pending: grant=0000, grant_idx=00, grant_valid=0, state=IDLE.
  - Timeout: req[o]=1 and hold_cnt==MAX_HOLD (MAX_HOLD>0).
    - timeout=1 for one cycle; ptr=o+1 mod 4; re-arbitrate at the same edge.
    - If o is the only requester, o is re-granted with hold_cnt=1. grant stays high continuously and timeout still pulses.
- Invariants:
  - grant is never multi-hot.
  - grant_idx always equals the encoding of grant.
  - grant_valid equals OR of grant.
- A requester that drops and re-raises req while not granted has no effect on the rotation order.
- req changes on the same edge as a release/timeout are sampled with the pre-edge value (standard registered semantics).
- Reset asserted mid-grant: all outputs clear immediately, without waiting for clk; ptr returns to 0.

Test Plan:
- Reset then req=0000 for 5 cycles -> grant=0000, grant_idx=00, grant_valid=0 throughout.
- req=0001 held 3 cycles, then 0000 -> grant=0001/idx=00 from the cycle after req rises, for 3 cycles; then 0000, valid=0, ptr=1.
- req=1111 held, each owner dropping its req after 2 cycles -> grant order Y0,Y1,Y2,Y3,Y0 with idx 00,01,10,11,00, back-to-back with no gap cycle.
- MAX_HOLD=8, req=0110 held constantly -> Y1 granted 8 cycles, timeout pulse, Y2 granted 8 cycles, timeout pulse, Y1 again; never two grant bits high.
- MAX_HOLD=8, req=1000 only, held 20 cycles -> grant=1000 continuously, idx=11, timeout pulses at cycles 8 and 16 of the grant.
- req=0100 granted; assert rst_n=0 between clock edges -> grant/idx/valid drop to 0 before the next edge; after release, req=1100 -> Y2 granted first (ptr=0, Y2 is the first requester found).

Source files
------------

// File: rtl/rr_encoder_arbiter.sv
// Four-requester round-robin arbiter with one-hot and binary-encoded registered grant.
// A grant is held while its owner keeps requesting, bounded by an optional time-slice.
module rr_encoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  logic       w_own_req;
  logic       w_keep;
  logic [1:0] w_base;
  logic [2:0] w_pick;

  // Returns {found, index} of the first requester at or after base, wrapping mod 4.
  function automatic logic [2:0] f_pick(input logic [3:0] req_v, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req_v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    w_own_req = req[grant_idx];
    w_keep    = (r_state == ST_GRANT) && w_own_req &&
                ((MAX_HOLD == 0) || (r_hold_cnt < HOLD_LIM));
    // On release or expiry the owner drops to lowest priority for the re-arbitration.
    w_base    = (r_state == ST_GRANT) ? grant_idx + 2'd1 : r_ptr;
    w_pick    = f_pick(req, w_base);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 2'd0;
      r_hold_cnt  <= '0;
      grant       <= 4'b0000;
      grant_idx   <= 2'b00;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick[2]) begin
            grant       <= 4'b0001 << w_pick[1:0];
            grant_idx   <= w_pick[1:0];
            grant_valid <= 1'b1;
            r_hold_cnt  <= CNT_W'(1);
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_keep) begin
            if (r_hold_cnt != '1) r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end else begin
            timeout <= w_own_req;
            r_ptr   <= grant_idx + 2'd1;
            if (w_pick[2]) begin
              grant      <= 4'b0001 << w_pick[1:0];
              grant_idx  <= w_pick[1:0];
              r_hold_cnt <= CNT_W'(1);
            end else begin
              grant       <= 4'b0000;
              grant_idx   <= 2'b00;
              grant_valid <= 1'b0;
              r_hold_cnt  <= '0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
